alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Iterative RV32M unsigned multiply/divide sequencer. It executes MUL, MULHU, DIVU and REMU by driving the shared 32-bit ALU once per cycle for 32 cycles.
- It also arbitrates the ALU. When idle, the ALU inputs pass through from the main datapath. While busy, the sequencer owns the ALU and stalls the datapath.
- It sits between the execute-stage datapath and the ALU instance.

Parameters:
- WIDTH, 32, operand/result width; fixed to the ALU width, other values unsupported.
- CNT_W, 5, iteration counter width; 2**CNT_W must equal WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  operation: 00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
- rs1  in  32  multiplicand / dividend.
- rs2  in  32  multiplier / divisor.
- busy  out  1  high in RUN and DONE; the datapath stalls on it.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  32  registered result; held until the next accepted start.
- dp_a, dp_b  in  32  datapath ALU operands.
- dp_fs  in  4  datapath ALU function select.
- dp_c0  in  1  datapath ALU carry-in.
- alu_a, alu_b  out  32  operands to the ALU.
- alu_fs  out  4  ALU function select. Encoding: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SLL, 6 SRL, 7 zero.
- alu_c0  out  1  ALU carry-in.
- alu_f  in  32  ALU result.
- alu_status  in  4  ALU flags {V,C,N,Z}; only C (bit 2) is used.

Behaviour:
- Registers: state, cnt[CNT_W-1:0], hi[31:0], lo[31:0], opnd[31:0], op_q[1:0], result[31:0].
- Reset (any state, including mid-operation): state=IDLE, cnt=0, hi=lo=opnd=0, result=0, busy=0, done=0. Any in-flight operation is discarded without a done pulse.
- IDLE:
  - alu_* = dp_* combinationally; busy=0.
  - When start=1, on the next edge: op_q=op, hi=0, lo=rs1, opnd=rs2, cnt=0, state=RUN.
- RUN, multiply (op_q[1]=0):
  - ALU drive: alu_a=hi, alu_b = lo[0] ? opnd : 0, alu_fs=4, alu_c0=0.
  - Update: hi={C, alu_f[31:1]}, lo={alu_f[0], lo[31:1]}.
- RUN, divide (op_q[1]=1), restoring algorithm:
  - Shifted remainder r = {hi[30:0], lo[31]}.
  - ALU drive: alu_a=r, alu_b=~opnd, alu_fs=4, alu_c0=1.
  - ok = hi[31] | C.
  - Update: hi = ok ? alu_f : r, lo = {lo[30:0], ok}.
- RUN counting and exit:
  - cnt increments each cycle.
  - On the cnt=31 edge, result is loaded and state=DONE. Result select: MUL lo, MULHU hi, DIVU lo, REMU hi, using post-update values.
  - start is ignored throughout RUN and DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - alu_* = dp_*.
  - Next state is IDLE.
  - A start arriving in this cycle is ignored; it must be re-presented in IDLE.
- Latency: start sampled at edge k; RUN occupies cycles k+1..k+32; done=1 in cycle k+33; a new start can be accepted at edge k+34.
- Divide by zero: no special case. Every subtract succeeds, giving DIVU=0xFFFFFFFF and REMU=rs1, which matches RISC-V.
- Overflow: MUL wraps modulo 2^32; there is no other overflow case.
- ALU flags V, N and Z are ignored.
- Signed ops (MULH, DIV, REM) are out of scope; the decoder routes them elsewhere.

Test Plan:
- MUL rs1=7, rs2=6 -> done exactly 33 cycles after the start edge; result=0x0000002A; busy high for 33 cycles.
- MUL and MULHU with rs1=rs2=0xFFFFFFFF -> MUL result=0x00000001; MULHU result=0xFFFFFFFE.
- DIVU rs1=100, rs2=7 -> result=14; REMU with the same operands -> result=2. Also DIVU 0x80000000/1 -> result=0x80000000.
- DIVU and REMU with rs1=0x1234, rs2=0 -> DIVU result=0xFFFFFFFF; REMU result=0x00001234.
- Arbitration and start filtering:
  - In IDLE, drive dp_a=5, dp_b=3, dp_fs=4 -> alu_a/alu_b/alu_fs mirror them in the same cycle.
  - Pulse start with op=10 in RUN cycle 5 and in DONE -> both ignored, exactly one done, result unchanged until the next IDLE start.
- Assert rst in RUN cycle 10 of a MUL -> the next cycle shows busy=0, done=0, result=0, alu_* following dp_*. No done pulse appears afterwards; a fresh MUL 3*4 then returns 12.

Source files
------------

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the execute-stage datapath and the
// multiply/divide sequencer.
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, rs1, rs2,
        input  busy, done, result
    );

    modport slave (
        input  start, op, rs1, rs2,
        output busy, done, result
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared ALU
// for one add per cycle and passes datapath operands through when it is idle.
module alu_muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    alu_muldiv_seq_if.slave  bus,
    input  logic [WIDTH-1:0] dp_a,
    input  logic [WIDTH-1:0] dp_b,
    input  logic [3:0]       dp_fs,
    input  logic             dp_c0,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_fs,
    output logic             alu_c0,
    input  logic [WIDTH-1:0] alu_f,
    input  logic [3:0]       alu_status
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] FS_ADD = 4'd4;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic             carry;
    logic             sub_ok;
    logic             unused_flags;

    assign carry        = alu_status[2];
    assign unused_flags = ^{alu_status[3], alu_status[1:0]};
    assign rem_shift    = {hi[WIDTH-2:0], lo[WIDTH-1]};
    // A set hi[31] means the shifted remainder exceeds 32 bits, so it always covers the divisor.
    assign sub_ok       = hi[WIDTH-1] | carry;

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    always_comb begin
        alu_a  = dp_a;
        alu_b  = dp_b;
        alu_fs = dp_fs;
        alu_c0 = dp_c0;
        if (state == RUN) begin
            alu_fs = FS_ADD;
            if (!op_q[1]) begin
                alu_a  = hi;
                alu_b  = lo[0] ? opnd : '0;
                alu_c0 = 1'b0;
            end else begin
                alu_a  = rem_shift;
                alu_b  = ~opnd;
                alu_c0 = 1'b1;
            end
        end
    end

    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        if (!op_q[1]) begin
            hi_nxt = {carry, alu_f[WIDTH-1:1]};
            lo_nxt = {alu_f[0], lo[WIDTH-1:1]};
        end else begin
            hi_nxt = sub_ok ? alu_f : rem_shift;
            lo_nxt = {lo[WIDTH-2:0], sub_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            op_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        hi     <= '0;
                        lo     <= bus.rs1;
                        opnd   <= bus.rs2;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    // MULHU and REMU (op bit 0 set) live in hi, MUL and DIVU in lo.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result_q <= op_q[0] ? hi_nxt : lo_nxt;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: a behavioural ALU, a cycle-level reference
// model with a per-cycle compare process, and hand-computed literal expectations.
`timescale 1ns/1ps
module tb_alu_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dp_a, dp_b, alu_a, alu_b, alu_f;
    logic [3:0]  dp_fs, alu_fs, alu_status;
    logic        dp_c0, alu_c0;
    logic [32:0] sum;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq_if #(.WIDTH(32)) bus_if ();

    alu_muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_fs      (dp_fs),
        .dp_c0      (dp_c0),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_fs     (alu_fs),
        .alu_c0     (alu_c0),
        .alu_f      (alu_f),
        .alu_status (alu_status)
    );

    always_comb begin
        sum   = 33'(alu_a) + 33'(alu_b) + 33'(alu_c0);
        alu_f = '0;
        case (alu_fs)
            4'd0:    alu_f = alu_a & alu_b;
            4'd1:    alu_f = alu_a | alu_b;
            4'd2:    alu_f = alu_a ^ alu_b;
            4'd3:    alu_f = ~(alu_a | alu_b);
            4'd4:    alu_f = sum[31:0];
            4'd5:    alu_f = alu_a << alu_b[4:0];
            4'd6:    alu_f = alu_a >> alu_b[4:0];
            default: alu_f = '0;
        endcase
        alu_status = {1'b0, (alu_fs == 4'd4) & sum[32], alu_f[31], alu_f == 32'd0};
    end

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference model: m_left counts the busy cycles still ahead (33 after an accepted start).
    int          m_left      = 0;
    logic [31:0] m_result    = '0;
    logic [31:0] m_pending   = '0;
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left      <= 0;
            m_result    <= '0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            if (m_left == 0) begin
                if (bus_if.start) begin
                    m_left    <= 33;
                    m_pending <= ref_op(bus_if.op, bus_if.rs1, bus_if.rs2);
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 2) m_result <= m_pending;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_valid) begin
            checkOutput("cyc_busy", 32'(bus_if.busy), 32'(m_left != 0));
            checkOutput("cyc_done", 32'(bus_if.done), 32'(m_left == 1));
            checkOutput("cyc_result", bus_if.result, m_result);
            if (m_left <= 1) begin
                checkOutput("cyc_pass_a", alu_a, dp_a);
                checkOutput("cyc_pass_b", alu_b, dp_b);
                checkOutput("cyc_pass_fs", 32'(alu_fs), 32'(dp_fs));
                checkOutput("cyc_pass_c0", 32'(alu_c0), 32'(dp_c0));
            end
        end
    end

    // mode 0: plain op; 1: stray starts in RUN cycle 5 and in DONE; 2: reset in RUN cycle 10.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int mode, output int cycles, output int busy_cycles);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.rs1   = a;
        bus_if.rs2   = b;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.op    = 2'($urandom);
        bus_if.rs1   = $urandom;
        bus_if.rs2   = $urandom;
        cycles       = 1;
        busy_cycles  = 0;
        forever begin
            if (bus_if.busy) busy_cycles++;
            if (bus_if.done) begin
                if (mode == 1) begin
                    bus_if.start = 1'b1;
                    bus_if.op    = 2'b10;
                    bus_if.rs1   = 32'd100;
                    bus_if.rs2   = 32'd7;
                end
                break;
            end
            if (cycles >= 60) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL done_timeout: actual=no done after %0d cycles required=done at 33", cycles);
                break;
            end
            dp_a  = $urandom;
            dp_b  = $urandom;
            dp_fs = 4'($urandom_range(0, 7));
            dp_c0 = 1'($urandom);
            if (mode == 1) begin
                bus_if.start = (cycles == 5);
                bus_if.op    = 2'b10;
            end
            if (mode == 2 && cycles == 10) begin
                rst = 1'b1;
                @(negedge clk);
                cycles++;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic runCheck(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int mode);
        int cycles, busy_cycles;
        checkOutput({name, "_model"}, ref_op(op, a, b), exp);
        applyStimulus(op, a, b, mode, cycles, busy_cycles);
        checkOutput({name, "_latency"}, 32'(cycles), 32'd33);
        checkOutput({name, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
        checkOutput({name, "_result"}, bus_if.result, exp);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles, busy_cycles, done_seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op    = 2'b00;
        bus_if.rs1   = '0;
        bus_if.rs2   = '0;
        dp_a         = '0;
        dp_b         = '0;
        dp_fs        = '0;
        dp_c0        = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(bus_if.busy), 32'd0);
        checkOutput("reset_done", 32'(bus_if.done), 32'd0);
        checkOutput("reset_result", bus_if.result, 32'd0);
        rst = 1'b0;

        dp_a  = 32'd5;
        dp_b  = 32'd3;
        dp_fs = 4'd4;
        dp_c0 = 1'b0;
        #1;
        checkOutput("idle_pass_a", alu_a, 32'd5);
        checkOutput("idle_pass_b", alu_b, 32'd3);
        checkOutput("idle_pass_fs", 32'(alu_fs), 32'd4);

        runCheck("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000_002A, 0);
        runCheck("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        runCheck("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        runCheck("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 0);
        runCheck("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 0);
        runCheck("divu_msb_1", 2'b10, 32'h8000_0000, 32'd1, 32'h8000_0000, 0);
        runCheck("divu_by0", 2'b10, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 0);
        runCheck("remu_by0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 0);

        runCheck("mul_stray", 2'b00, 32'd7, 32'd6, 32'h0000_002A, 1);
        @(negedge clk);
        bus_if.start = 1'b0;
        checkOutput("stray_done_start_ignored", 32'(bus_if.busy), 32'd0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_if.done) done_seen++;
            checkOutput("stray_result_held", bus_if.result, 32'h0000_002A);
        end
        checkOutput("stray_no_extra_done", 32'(done_seen), 32'd0);

        applyStimulus(2'b00, 32'h55, 32'h77, 2, cycles, busy_cycles);
        checkOutput("rst_mid_busy", 32'(bus_if.busy), 32'd0);
        checkOutput("rst_mid_done", 32'(bus_if.done), 32'd0);
        checkOutput("rst_mid_result", bus_if.result, 32'd0);
        checkOutput("rst_mid_pass_a", alu_a, dp_a);
        checkOutput("rst_mid_pass_b", alu_b, dp_b);
        checkOutput("rst_mid_pass_fs", 32'(alu_fs), 32'(dp_fs));
        rst       = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus_if.done) done_seen++;
        end
        checkOutput("rst_no_late_done", 32'(done_seen), 32'd0);
        runCheck("mul_after_rst", 2'b00, 32'd3, 32'd4, 32'd12, 0);

        for (int i = 0; i < 6; i++) begin
            rop = 2'(i % 4);
            ra  = $urandom;
            rb  = (i >= 4) ? 32'($urandom_range(1, 300)) : $urandom;
            applyStimulus(rop, ra, rb, 0, cycles, busy_cycles);
            checkOutput("rand_latency", 32'(cycles), 32'd33);
            checkOutput("rand_result", bus_if.result, ref_op(rop, ra, rb));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
